// File: rtl/popcount18_vec_enum_if.sv
// Output stream of the k-ones vector enumerator.
//   vec_valid : source has a vector on vec_data
//   vec_ready : sink accepts the vector when vec_valid & vec_ready
//   vec_data  : current N-bit vector
//   vec_last  : final vector of the current enumeration
// The master modport is the enumerator. The slave modport is the consumer.
interface popcount18_vec_enum_if #(
  parameter int N = 18
);
  logic         vec_valid;
  logic         vec_ready;
  logic [N-1:0] vec_data;
  logic         vec_last;

  modport master (output vec_valid, output vec_data, output vec_last, input vec_ready);
  modport slave  (input vec_valid, input vec_data, input vec_last, output vec_ready);
endinterface

// File: rtl/popcount18_vec_enum.sv
// popcount18_vec_enum: given a target count k, this block streams every N-bit
// vector that has exactly k ones. The vectors come out in increasing numeric
// (colex) order, one per cycle while the consumer is ready.
// Ports:
//   clk, rst_n : clock and asynchronous active-low reset
//   start      : request enumeration of count_in (sampled only in IDLE)
//   count_in   : target number of ones k
//   abort      : stop the stream and return to IDLE
//   busy       : an enumeration is in progress
//   err        : 1-cycle pulse when start is seen with count_in > N
//   vec_total  : vectors handshaken since the last accepted start
//   done       : 1-cycle pulse after the final handshake or an abort
//   vec_if     : vector stream (master side)
module popcount18_vec_enum #(
  parameter int N  = 18,
  parameter int CW = 5,
  parameter int TW = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [CW-1:0]         count_in,
  input  logic                  abort,
  output logic                  busy,
  output logic                  err,
  output logic [TW-1:0]         vec_total,
  output logic                  done,
  popcount18_vec_enum_if.master vec_if
);

  typedef enum logic {IDLE, EMIT} state_t;

  state_t        state, state_nxt;
  logic [CW-1:0] k_q;
  logic [N-1:0]  vec_q;
  logic [N-1:0]  vec_nxt;
  logic [N-1:0]  first_pat;
  logic [N-1:0]  last_pat;
  logic          start_ok;
  logic          start_bad;
  logic          hs;
  logic          is_last;

  assign start_ok  = (state == IDLE) && start && (count_in <= CW'(N));
  assign start_bad = (state == IDLE) && start && (count_in >  CW'(N));
  assign hs        = vec_if.vec_valid && vec_if.vec_ready;

  // first_pat sets the low count_in bits. last_pat sets the top k_q bits.
  always_comb begin
    first_pat = '0;
    last_pat  = '0;
    for (int i = 0; i < N; i++) begin
      first_pat[i] = (i < int'(count_in));
      last_pat[i]  = (i >= N - int'(k_q));
    end
  end

  assign is_last = (vec_q == last_pat);

  // Gosper step, computed N+1 bits wide.
  // c is the lowest set bit of v. r = v + c carries the lowest block of ones
  // upward. The remaining ones of that block are right-justified again by
  // shifting (r ^ v) down by tz(c) + 2. Because c is one-hot, tz(c) is the
  // OR of the indices of its set bits, so no priority encoder or divider is
  // needed. For a non-last vector the carry never reaches bit N, so
  // truncating the result is exact.
  logic [N:0] v_w, c_w, r_w, sh_w;
  logic [4:0] tz;
  always_comb begin
    v_w = {1'b0, vec_q};
    c_w = v_w & (~v_w + (N+1)'(1));
    r_w = v_w + c_w;
    tz  = '0;
    for (int i = 0; i <= N; i++)
      if (c_w[i]) tz = tz | 5'(i);
    sh_w    = (r_w ^ v_w) >> (int'(tz) + 2);
    vec_nxt = N'(r_w | sh_w);
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic. abort takes priority over a same-cycle handshake.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (start_ok) state_nxt = EMIT;
      EMIT: if (abort || (hs && is_last)) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Output logic. The stream is valid for exactly the EMIT cycles.
  always_comb begin
    busy             = (state == EMIT);
    vec_if.vec_valid = (state == EMIT);
    vec_if.vec_last  = (state == EMIT) && is_last;
    vec_if.vec_data  = vec_q;
  end

  // Datapath registers: vector, count, and the err/done pulses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      k_q       <= '0;
      vec_q     <= '0;
      vec_total <= '0;
      err       <= 1'b0;
      done      <= 1'b0;
    end else begin
      err  <= start_bad;
      done <= 1'b0;
      if (start_ok) begin
        k_q       <= count_in;
        vec_q     <= first_pat;
        vec_total <= '0;
      end else if (state == EMIT) begin
        if (abort) begin
          done <= 1'b1;
        end else if (hs) begin
          vec_total <= vec_total + TW'(1);
          if (is_last) done  <= 1'b1;
          else         vec_q <= vec_nxt;
        end
      end
    end
  end

endmodule

// File: tb/tb_popcount18_vec_enum.sv
// Directed bench for popcount18_vec_enum. It covers k=0, k=2, k=18, k=19,
// a stall, an abort, a reset in the middle of a stream, and a full k=9 sweep.
module tb_popcount18_vec_enum;
  localparam int N = 18, CW = 5, TW = 16;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic [CW-1:0] count_in = '0;
  logic          abort = 1'b0;
  logic          busy, err, done;
  logic [TW-1:0] vec_total;

  popcount18_vec_enum_if #(.N(N)) vif ();

  popcount18_vec_enum #(.N(N), .CW(CW), .TW(TW)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .count_in(count_in),
    .abort(abort), .busy(busy), .err(err), .vec_total(vec_total),
    .done(done), .vec_if(vif)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s got %h exp %h", tag, obs, exp);
    end
  endtask

  // Inputs are driven, and outputs sampled, 1 time unit after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic go(input int k);
    start = 1'b1;
    count_in = CW'(k);
    tick();
    start = 1'b0;
  endtask

  // Run one enumeration to its end. The consumer drops ready at random
  // unless rdy_all is set. Per-vector properties are checked here:
  // popcount equals k, order is strictly increasing, and the vector holds
  // while stalled.
  logic [N-1:0] first4 [4];
  task automatic run(input string tag, input int k, input bit rdy_all,
                     input int exp_cnt, input logic [N-1:0] exp_last);
    int           cnt = 0, bad_pop = 0, bad_ord = 0, bad_stb = 0;
    bit           held = 0, have_prev = 0, seen_last = 0;
    logic [N:0]   held_v = '0;
    logic [N-1:0] prev = '0, last_v = '0;
    go(k);
    for (int cyc = 0; cyc < 60000 && !seen_last; cyc++) begin
      vif.vec_ready = rdy_all ? 1'b1 : ($urandom_range(0, 15) != 0);
      if (vif.vec_valid) begin
        if (held) begin
          if ({vif.vec_last, vif.vec_data} !== held_v) bad_stb++;
        end else begin
          if ($countones(vif.vec_data) != k) bad_pop++;
          if (have_prev && !(vif.vec_data > prev)) bad_ord++;
          if (cnt < 4) first4[cnt] = vif.vec_data;
        end
        if (vif.vec_ready) begin
          cnt++;
          prev = vif.vec_data;
          have_prev = 1;
          held = 0;
          if (vif.vec_last) begin
            seen_last = 1;
            last_v = vif.vec_data;
          end
        end else begin
          held = 1;
          held_v = {vif.vec_last, vif.vec_data};
        end
      end
      tick();
    end
    vif.vec_ready = 1'b0;
    chk({tag, " seen_last"}, 32'(seen_last), 32'd1);
    chk({tag, " count"}, cnt, exp_cnt);
    chk({tag, " last_data"}, 32'(last_v), 32'(exp_last));
    chk({tag, " done"}, 32'(done), 32'd1);
    chk({tag, " valid_off"}, 32'(vif.vec_valid), 32'd0);
    chk({tag, " busy_off"}, 32'(busy), 32'd0);
    chk({tag, " total"}, 32'(vec_total), exp_cnt);
    chk({tag, " bad_pop"}, bad_pop, 0);
    chk({tag, " bad_order"}, bad_ord, 0);
    chk({tag, " bad_stable"}, bad_stb, 0);
    tick();
    chk({tag, " done_pulse"}, 32'(done), 32'd0);
  endtask

  initial begin
    vif.vec_ready = 1'b0;
    #12;
    chk("rst valid", 32'(vif.vec_valid), 0);
    chk("rst busy",  32'(busy), 0);
    chk("rst data",  32'(vif.vec_data), 0);
    chk("rst last",  32'(vif.vec_last), 0);
    chk("rst total", 32'(vec_total), 0);
    chk("rst done",  32'(done), 0);
    chk("rst err",   32'(err), 0);
    rst_n = 1'b1;
    tick();

    // k=0: the single vector is 0 and is also the last one.
    vif.vec_ready = 1'b1;
    go(0);
    chk("k0 valid", 32'(vif.vec_valid), 1);
    chk("k0 data",  32'(vif.vec_data), 0);
    chk("k0 last",  32'(vif.vec_last), 1);
    tick();
    chk("k0 done",  32'(done), 1);
    chk("k0 valid_off", 32'(vif.vec_valid), 0);
    chk("k0 total", 32'(vec_total), 1);
    vif.vec_ready = 1'b0;
    tick();

    // k=2: C(18,2) = 153 vectors, starting 3, 5, 6, 9 and ending at 0x30000.
    run("k2", 2, 1'b1, 153, 18'h30000);
    chk("k2 v0", 32'(first4[0]), 32'h3);
    chk("k2 v1", 32'(first4[1]), 32'h5);
    chk("k2 v2", 32'(first4[2]), 32'h6);
    chk("k2 v3", 32'(first4[3]), 32'h9);

    // k=18: all ones, single vector.
    run("k18", 18, 1'b1, 1, 18'h3FFFF);

    // k=19 is out of range: err pulses and no stream starts.
    go(19);
    chk("k19 err",   32'(err), 1);
    chk("k19 busy",  32'(busy), 0);
    chk("k19 valid", 32'(vif.vec_valid), 0);
    tick();
    chk("k19 err_pulse", 32'(err), 0);
    chk("k19 valid2", 32'(vif.vec_valid), 0);

    // k=5: stall for 7 cycles, then 0x1F is followed by 0x2F.
    vif.vec_ready = 1'b0;
    go(5);
    for (int i = 0; i < 7; i++) begin
      chk("k5 stall_data",  32'(vif.vec_data), 32'h1F);
      chk("k5 stall_valid", 32'(vif.vec_valid), 1);
      tick();
    end
    vif.vec_ready = 1'b1;
    tick();
    vif.vec_ready = 1'b0;
    chk("k5 next", 32'(vif.vec_data), 32'h2F);
    chk("k5 total", 32'(vec_total), 1);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("k5 abort_done", 32'(done), 1);
    tick();

    // k=4: abort in the same cycle as the 10th handshake (vector 0x33).
    vif.vec_ready = 1'b1;
    go(4);
    for (int i = 0; i < 9; i++) tick();
    chk("k4 v10", 32'(vif.vec_data), 32'h33);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    vif.vec_ready = 1'b0;
    chk("k4 abort_total", 32'(vec_total), 9);
    chk("k4 abort_done",  32'(done), 1);
    chk("k4 abort_valid", 32'(vif.vec_valid), 0);
    chk("k4 abort_busy",  32'(busy), 0);
    tick();

    // Reset in the middle of a stream clears everything at once.
    vif.vec_ready = 1'b1;
    go(3);
    tick();
    tick();
    rst_n = 1'b0;
    #1;
    chk("mrst valid", 32'(vif.vec_valid), 0);
    chk("mrst busy",  32'(busy), 0);
    chk("mrst data",  32'(vif.vec_data), 0);
    chk("mrst total", 32'(vec_total), 0);
    chk("mrst last",  32'(vif.vec_last), 0);
    tick();
    chk("mrst done",  32'(done), 0);
    rst_n = 1'b1;
    vif.vec_ready = 1'b0;
    tick();

    // k=9: all C(18,9) = 48620 vectors, with random ready.
    run("k9", 9, 1'b0, 48620, 18'h3FE00);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end
endmodule
